// File: rtl/te_block_fifo.sv
// ---------------------------------------------------------------------------
// mure_pkg: field widths of a retirement instruction block.
// te_block_fifo: elastic buffer between the retirement-block FSM and the trace
// encoder. Blocks arrive as single-cycle pulses with no backpressure and are
// stored in a DEPTH-entry FIFO. They leave over a valid/ready handshake. When
// the FIFO is full and the head is not leaving, a new block is dropped and
// counted instead of stalling the core.
//
// Ports
//   clk_i, rst_i            clock, synchronous active-high reset
//   valid_i + *_i fields    incoming block (one cycle per block)
//   valid_o, ready_i        head-entry handshake toward the encoder
//   *_o fields              head entry, don't-care while valid_o = 0
//   count_o, full_o         registered occupancy and full flag
//   overflow_o, drop_cnt_o  sticky drop flag and saturating drop counter
//   clear_drop_i            clears overflow_o and drop_cnt_o
// ---------------------------------------------------------------------------
package mure_pkg;
   localparam int unsigned IRETIRE_LEN = 32;
   localparam int unsigned ITYPE_LEN   = 3;
   localparam int unsigned CAUSE_LEN   = 5;
   localparam int unsigned XLEN        = 64;
   localparam int unsigned PRIV_LEN    = 2;
endpackage

module te_block_fifo #(
   parameter int unsigned DEPTH        = 4,
   parameter int unsigned DROP_CNT_LEN = 8
) (
   input  logic                             clk_i,
   input  logic                             rst_i,
   input  logic                             valid_i,
   input  logic [mure_pkg::IRETIRE_LEN-1:0] iretire_i,
   input  logic                             ilastsize_i,
   input  logic [mure_pkg::ITYPE_LEN-1:0]   itype_i,
   input  logic [mure_pkg::CAUSE_LEN-1:0]   cause_i,
   input  logic [mure_pkg::XLEN-1:0]        tval_i,
   input  logic [mure_pkg::PRIV_LEN-1:0]    priv_i,
   input  logic [mure_pkg::XLEN-1:0]        iaddr_i,
   output logic                             valid_o,
   input  logic                             ready_i,
   output logic [mure_pkg::IRETIRE_LEN-1:0] iretire_o,
   output logic                             ilastsize_o,
   output logic [mure_pkg::ITYPE_LEN-1:0]   itype_o,
   output logic [mure_pkg::CAUSE_LEN-1:0]   cause_o,
   output logic [mure_pkg::XLEN-1:0]        tval_o,
   output logic [mure_pkg::PRIV_LEN-1:0]    priv_o,
   output logic [mure_pkg::XLEN-1:0]        iaddr_o,
   output logic [$clog2(DEPTH):0]           count_o,
   output logic                             full_o,
   output logic                             overflow_o,
   output logic [DROP_CNT_LEN-1:0]          drop_cnt_o,
   input  logic                             clear_drop_i
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   typedef struct packed {
      logic [mure_pkg::IRETIRE_LEN-1:0] iretire;
      logic                             ilastsize;
      logic [mure_pkg::ITYPE_LEN-1:0]   itype;
      logic [mure_pkg::CAUSE_LEN-1:0]   cause;
      logic [mure_pkg::XLEN-1:0]        tval;
      logic [mure_pkg::PRIV_LEN-1:0]    priv;
      logic [mure_pkg::XLEN-1:0]        iaddr;
   } blk_t;

   blk_t              mem [DEPTH];
   blk_t              wr_blk;
   blk_t              head;
   logic [AW-1:0]     wptr;
   logic [AW-1:0]     rptr;
   logic [CW-1:0]     count;
   logic              overflow;
   logic [DROP_CNT_LEN-1:0] drop_cnt;
   logic              full;
   logic              push;
   logic              pop;
   logic              drop;

   assign full = (count == CW'(DEPTH));

   // A full FIFO still accepts a block when the head leaves in the same
   // cycle: the slot being freed is the one wptr points at.
   assign pop  = valid_o && ready_i;
   assign push = valid_i && (!full || pop);
   assign drop = valid_i && full && !pop;

   always_comb begin
      wr_blk           = '0;
      wr_blk.iretire   = iretire_i;
      wr_blk.ilastsize = ilastsize_i;
      wr_blk.itype     = itype_i;
      wr_blk.cause     = cause_i;
      wr_blk.tval      = tval_i;
      wr_blk.priv      = priv_i;
      wr_blk.iaddr     = iaddr_i;
   end

   // Storage has no reset; a push in the reset cycle is ignored.
   always_ff @(posedge clk_i) begin
      if (push && !rst_i) begin
         mem[wptr] <= wr_blk;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wptr     <= '0;
         rptr     <= '0;
         count    <= '0;
         overflow <= 1'b0;
         drop_cnt <= '0;
      end else begin
         if (push) wptr <= wptr + AW'(1);
         if (pop)  rptr <= rptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
         // Clear is applied first, so a same-cycle drop leaves a count of 1.
         if (drop) begin
            overflow <= 1'b1;
            if (clear_drop_i) begin
               drop_cnt <= DROP_CNT_LEN'(1);
            end else if (drop_cnt != '1) begin
               drop_cnt <= drop_cnt + DROP_CNT_LEN'(1);
            end
         end else if (clear_drop_i) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
         end
      end
   end

   assign head        = mem[rptr];
   assign valid_o     = (count != '0);
   assign iretire_o   = head.iretire;
   assign ilastsize_o = head.ilastsize;
   assign itype_o     = head.itype;
   assign cause_o     = head.cause;
   assign tval_o      = head.tval;
   assign priv_o      = head.priv;
   assign iaddr_o     = head.iaddr;
   assign count_o     = count;
   assign full_o      = full;
   assign overflow_o  = overflow;
   assign drop_cnt_o  = drop_cnt;

endmodule

// File: tb/tb_te_block_fifo.sv
// ---------------------------------------------------------------------------
// Testbench for te_block_fifo. Accepted blocks are pushed to a scoreboard
// queue as they are driven and popped/compared when the DUT hands them out.
// ---------------------------------------------------------------------------
module tb_te_block_fifo;

   localparam int unsigned DEPTH        = 4;
   localparam int unsigned DROP_CNT_LEN = 8;
   localparam int unsigned CW           = $clog2(DEPTH) + 1;

   typedef struct packed {
      logic [mure_pkg::IRETIRE_LEN-1:0] iretire;
      logic                             ilastsize;
      logic [mure_pkg::ITYPE_LEN-1:0]   itype;
      logic [mure_pkg::CAUSE_LEN-1:0]   cause;
      logic [mure_pkg::XLEN-1:0]        tval;
      logic [mure_pkg::PRIV_LEN-1:0]    priv;
      logic [mure_pkg::XLEN-1:0]        iaddr;
   } blk_t;

   logic                             clk = 1'b0;
   logic                             rst_i = 1'b1;
   logic                             valid_i = 1'b0;
   blk_t                             cur = '0;
   logic                             ready_i = 1'b0;
   logic                             clear_drop_i = 1'b0;
   logic                             valid_o;
   logic [mure_pkg::IRETIRE_LEN-1:0] iretire_o;
   logic                             ilastsize_o;
   logic [mure_pkg::ITYPE_LEN-1:0]   itype_o;
   logic [mure_pkg::CAUSE_LEN-1:0]   cause_o;
   logic [mure_pkg::XLEN-1:0]        tval_o;
   logic [mure_pkg::PRIV_LEN-1:0]    priv_o;
   logic [mure_pkg::XLEN-1:0]        iaddr_o;
   logic [CW-1:0]                    count_o;
   logic                             full_o;
   logic                             overflow_o;
   logic [DROP_CNT_LEN-1:0]          drop_cnt_o;

   blk_t q[$];
   int   mdrop = 0;
   bit   movf  = 1'b0;
   int   n_checks = 0;
   int   n_errors = 0;

   always #5 clk = ~clk;

   te_block_fifo #(.DEPTH(DEPTH), .DROP_CNT_LEN(DROP_CNT_LEN)) dut (
      .clk_i       (clk),
      .rst_i       (rst_i),
      .valid_i     (valid_i),
      .iretire_i   (cur.iretire),
      .ilastsize_i (cur.ilastsize),
      .itype_i     (cur.itype),
      .cause_i     (cur.cause),
      .tval_i      (cur.tval),
      .priv_i      (cur.priv),
      .iaddr_i     (cur.iaddr),
      .valid_o     (valid_o),
      .ready_i     (ready_i),
      .iretire_o   (iretire_o),
      .ilastsize_o (ilastsize_o),
      .itype_o     (itype_o),
      .cause_o     (cause_o),
      .tval_o      (tval_o),
      .priv_o      (priv_o),
      .iaddr_o     (iaddr_o),
      .count_o     (count_o),
      .full_o      (full_o),
      .overflow_o  (overflow_o),
      .drop_cnt_o  (drop_cnt_o),
      .clear_drop_i(clear_drop_i)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // One clock cycle: outputs are sampled at the falling edge, the model is
   // advanced with the inputs held during the cycle, then registered status is
   // checked just after the rising edge.
   task automatic cycle();
      bit pop_m, full_m, drop_m;
      @(negedge clk);
      if (rst_i) begin
         q.delete();
         mdrop = 0;
         movf  = 1'b0;
      end else begin
         check("valid_o", {63'd0, valid_o}, {63'd0, q.size() != 0});
         if (q.size() != 0) begin
            check("iaddr_o",   iaddr_o, q[0].iaddr);
            check("iretire_o", {32'd0, iretire_o}, {32'd0, q[0].iretire});
            check("tval_o",    tval_o, q[0].tval);
            check("misc_o",    {53'd0, ilastsize_o, itype_o, cause_o, priv_o},
                               {53'd0, q[0].ilastsize, q[0].itype, q[0].cause, q[0].priv});
         end
         full_m = (q.size() == DEPTH);
         pop_m  = (q.size() != 0) && ready_i;
         drop_m = valid_i && full_m && !pop_m;
         if (pop_m) void'(q.pop_front());
         if (valid_i && (!full_m || pop_m)) q.push_back(cur);
         if (clear_drop_i) begin
            mdrop = 0;
            movf  = 1'b0;
         end
         if (drop_m) begin
            movf = 1'b1;
            if (mdrop < (1 << DROP_CNT_LEN) - 1) mdrop++;
         end
      end
      @(posedge clk);
      #1;
      check("count_o",    {{(64-CW){1'b0}}, count_o}, 64'(q.size()));
      check("full_o",     {63'd0, full_o}, {63'd0, q.size() == DEPTH});
      check("overflow_o", {63'd0, overflow_o}, {63'd0, movf});
      check("drop_cnt_o", {56'd0, drop_cnt_o}, 64'(mdrop));
   endtask

   task automatic set_blk(input logic [63:0] addr, input logic [31:0] iret);
      valid_i       = 1'b1;
      cur.iaddr     = addr;
      cur.iretire   = iret;
      cur.tval      = {$urandom, $urandom};
      cur.ilastsize = 1'($urandom);
      cur.itype     = 3'($urandom);
      cur.cause     = 5'($urandom);
      cur.priv      = 2'($urandom);
   endtask

   task automatic push(input logic [63:0] addr, input logic [31:0] iret);
      set_blk(addr, iret);
      cycle();
      valid_i = 1'b0;
   endtask

   task automatic drain();
      ready_i = 1'b1;
      for (int i = 0; i < DEPTH + 1; i++) cycle();
      ready_i = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset
      rst_i = 1'b1;
      cycle();
      cycle();
      rst_i = 1'b0;
      check("reset_valid", {63'd0, valid_o}, 64'd0);

      // Single block
      set_blk(64'h8000_0000, 32'd3);
      cur.itype = '0;
      cycle();
      valid_i = 1'b0;
      check("single_valid", {63'd0, valid_o}, 64'd1);
      check("single_addr", iaddr_o, 64'h8000_0000);
      cycle();
      ready_i = 1'b1;
      cycle();
      ready_i = 1'b0;
      cycle();
      check("single_empty", {{(64-CW){1'b0}}, count_o}, 64'd0);

      // Fill and drop
      for (int i = 1; i <= 5; i++) push(64'(i * 16), 32'(i));
      check("fill_drop_cnt", {56'd0, drop_cnt_o}, 64'd1);
      check("fill_full", {63'd0, full_o}, 64'd1);
      drain();

      // Full with simultaneous push and pop
      for (int i = 1; i <= 4; i++) push(64'(i * 16), 32'(i));
      ready_i = 1'b1;
      set_blk(64'h50, 32'd5);
      cycle();
      valid_i = 1'b0;
      ready_i = 1'b0;
      check("pp_count", {{(64-CW){1'b0}}, count_o}, 64'd4);
      check("pp_drop", {56'd0, drop_cnt_o}, 64'd1);
      drain();

      // Saturation and clear
      for (int i = 1; i <= 4; i++) push(64'(i * 16), 32'(i));
      for (int i = 0; i < 300; i++) push(64'h1000 + 64'(i), 32'(i));
      check("sat_cnt", {56'd0, drop_cnt_o}, 64'd255);
      clear_drop_i = 1'b1;
      cycle();
      check("clr_cnt", {56'd0, drop_cnt_o}, 64'd0);
      check("clr_ovf", {63'd0, overflow_o}, 64'd0);
      set_blk(64'hdead, 32'd9);
      cycle();
      valid_i      = 1'b0;
      clear_drop_i = 1'b0;
      check("clr_drop_cnt", {56'd0, drop_cnt_o}, 64'd1);
      check("clr_drop_ovf", {63'd0, overflow_o}, 64'd1);
      drain();

      // Streaming
      ready_i = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         set_blk(64'h2000 + 64'(i), 32'(i));
         cycle();
         check("stream_le1", {63'd0, count_o <= CW'(1)}, 64'd1);
      end
      valid_i = 1'b0;
      cycle();
      cycle();
      ready_i = 1'b0;

      // Reset mid-operation
      for (int i = 1; i <= 3; i++) push(64'h3000 + 64'(i), 32'(i));
      rst_i = 1'b1;
      set_blk(64'h3999, 32'd7);
      cycle();
      rst_i   = 1'b0;
      valid_i = 1'b0;
      check("rst_count", {{(64-CW){1'b0}}, count_o}, 64'd0);
      check("rst_valid", {63'd0, valid_o}, 64'd0);
      push(64'h4000, 32'd11);
      check("post_rst_valid", {63'd0, valid_o}, 64'd1);
      drain();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/te_block_fifo.md
# te_block_fifo

Elastic buffer downstream of the retirement-block FSM in the CVA6 trace-encoder connector. The FSM emits one single-cycle instruction block (iretire, ilastsize, itype, cause, tval, priv, iaddr) with no backpressure; this block stores blocks in a DEPTH-entry FIFO and presents them to the trace encoder over a valid/ready handshake. When the encoder stalls long enough to fill the FIFO, new blocks are dropped and counted rather than stalling the core.

## Interface
- DEPTH, 4, number of stored blocks; power of two, at least 2
- DROP_CNT_LEN, 8, width of the saturating drop counter
- clk_i  in  1  clock; all logic samples on its rising edge
- rst_i  in  1  synchronous, active-high reset
- valid_i  in  1  FSM block valid; single cycle per block
- iretire_i  in  mure_pkg::IRETIRE_LEN  retired halfword count
- ilastsize_i  in  1  last instruction size (1 = 32-bit)
- itype_i  in  mure_pkg::ITYPE_LEN  block type
- cause_i  in  mure_pkg::CAUSE_LEN  trap cause
- tval_i  in  mure_pkg::XLEN  trap value
- priv_i  in  mure_pkg::PRIV_LEN  privilege level
- iaddr_i  in  mure_pkg::XLEN  first instruction address of block
- valid_o  out  1  head entry available
- ready_i  in  1  encoder accepts head entry
- iretire_o, ilastsize_o, itype_o, cause_o, tval_o, priv_o, iaddr_o  out  same widths as inputs  head entry fields
- count_o  out  $clog2(DEPTH)+1  current occupancy
- full_o  out  1  count_o == DEPTH
- overflow_o  out  1  sticky: at least one block dropped since reset/clear
- drop_cnt_o  out  DROP_CNT_LEN  dropped blocks, saturating at all-ones
- clear_drop_i  in  1  clears overflow_o and drop_cnt_o

## Operation
- Storage: DEPTH-entry array; write pointer, read pointer and occupancy counter. Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- Push: valid_i && (!full_o || pop). The entry is written at wptr and wptr increments.
- Pop: valid_o && ready_i. rptr increments.
- Occupancy: count +1 on push only, -1 on pop only, unchanged on push and pop together.
- Full with simultaneous pop: the push is accepted. The slot freed this cycle is reused and no drop occurs.
- Drop: valid_i && full_o && !pop. Storage and pointers are unchanged. overflow_o is set. drop_cnt_o increments unless it is already all-ones.
- Clear: clear_drop_i zeroes overflow_o and drop_cnt_o. If a drop happens in the same cycle, the result is overflow_o=1 and drop_cnt_o=1 (the drop is counted after the clear).
- Outputs: valid_o = (count != 0). Field outputs are driven from entry[rptr] and are don't-care while valid_o=0.
- Output stability: while valid_o=1 and ready_i=0, all field outputs hold stable.
- Ordering: blocks leave in strict arrival order. No field is modified.
- No fall-through: a block pushed into an empty FIFO is not visible at the outputs in the same cycle.

## Timing
- Reset values (synchronous, rst_i high at a clock edge): pointers 0, count_o 0, valid_o 0, full_o 0, overflow_o 0, drop_cnt_o 0. Stored entries are not cleared.
- Reset mid-operation: all buffered blocks are discarded. Pushes and pops in the reset cycle are ignored.
- Latency: a block pushed at edge N is on the outputs with valid_o=1 after edge N, i.e. 1 cycle on an empty FIFO.
- Throughput: one push and one pop per cycle. With ready_i held high, the FIFO sustains back-to-back blocks.
- Status outputs: count_o, full_o, overflow_o and drop_cnt_o are registered and reflect state after the last edge.
- Drop decision: uses full_o and the pop condition as seen in the same cycle.
- ready_i: may be asserted while valid_o=0. This has no effect.

## Test plan
- Single block: after reset, push iaddr_i=0x8000_0000, iretire_i=3, itype_i=0 with ready_i=0. Next cycle valid_o=1 with the same fields and count_o=1. Raise ready_i for one cycle, then valid_o=0 and count_o=0.
- Fill and drop (DEPTH=4): ready_i=0, push iaddr 0x10, 0x20, 0x30, 0x40, 0x50. Then full_o=1, overflow_o=1, drop_cnt_o=1. Draining yields 0x10..0x40 in order; 0x50 is never output.
- Full with simultaneous push/pop: from full (0x10..0x40), push 0x50 with ready_i=1. Output is 0x10, count_o stays 4, drop_cnt_o is unchanged. Drain order is 0x20, 0x30, 0x40, 0x50, which exercises pointer wrap.
- Saturation and clear (DROP_CNT_LEN=8): hold full and push 300 blocks. drop_cnt_o=255 and overflow_o=1. Pulse clear_drop_i alone: both become 0. Pulse clear_drop_i together with a drop: drop_cnt_o=1 and overflow_o=1.
- Streaming: ready_i=1 with 20 back-to-back valid_i blocks of iretire 1..20. Outputs show 1..20 each one cycle later, count_o never exceeds 1, and there are no drops.
- Reset mid-operation: with 3 blocks stored, assert rst_i for one cycle together with valid_i=1. Afterwards count_o=0, valid_o=0 and drop_cnt_o=0. The next push appears normally.
